piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 97 +++++++++
 tb/tb_piso_serializer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter. A WIDTH-bit word goes out one bit per cycle,
// optionally followed by an even-parity bit, with valid/ready on both sides.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);

  localparam int FLEN = WIDTH + PARITY_EN;
  localparam int CW   = $clog2(FLEN + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             last_bit;
  logic             data_bit;
  logic             take_load;

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] s);
    if (MSB_FIRST != 0) return {s[WIDTH-2:0], 1'b0};
    else                return {1'b0, s[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  assign last_bit = (cnt_q == '0);

  // load_ready is the only output with a combinational path (from sout_ready),
  // which lets a new word load on the final bit handshake with no idle cycle.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    load_ready = 1'b0;
    take_load  = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        take_load  = load_valid;
      end
      SHIFT: begin
        load_ready = last_bit && sout_ready;
        if (sout_ready) begin
          if (!last_bit) begin
            sreg_d = shift_out(sreg_q);
            cnt_d  = cnt_q - CW'(1);
          end else if (load_valid) begin
            take_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (take_load) begin
      sreg_d  = load_data;
      par_d   = ^load_data;
      cnt_d   = CW'(FLEN - 1);
      state_d = SHIFT;
    end
  end

  assign data_bit   = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
  assign sout_valid = (state_q == SHIFT);
  assign busy       = sout_valid;
  assign sout_last  = sout_valid && last_bit;
  assign sout       = sout_valid && (((PARITY_EN != 0) && last_bit) ? par_q : data_bit);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first/no parity, LSB-first/parity)
// checked every cycle against a queue-of-bits frame model plus literal expectations.
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transmitted bit i of a frame lands in result[i].
  function automatic logic [32:0] frame_bits(input logic [7:0] d, input bit msb, input bit par);
    logic [32:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = msb ? d[7-i] : d[i];
    if (par) r[8] = ^d;
    return r;
  endfunction

  function automatic logic [31:0] pack(input bit q[$], input int s, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], q[s+i]};
    return v;
  endfunction

  // ---------------- instance A: MSB first, no parity
  logic       a_rst = 1'b1, a_lv = 1'b0, a_sr = 1'b1;
  logic [7:0] a_ld = '0;
  logic       a_lr, a_so, a_sv, a_sl, a_busy;
  bit         a_en = 1'b0;
  bit         a_q[$];
  bit         a_bits[$];
  int         a_nlast = 0;
  bit         a_rdy_m;
  logic [32:0] a_fb;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) u_a (
    .clk(clk), .rst(a_rst), .load_valid(a_lv), .load_ready(a_lr), .load_data(a_ld),
    .sout(a_so), .sout_valid(a_sv), .sout_ready(a_sr), .sout_last(a_sl), .busy(a_busy));

  always @(posedge clk) begin
    if (a_rst) a_q.delete();
    else begin
      a_rdy_m = (a_q.size() == 0) || (a_q.size() == 1 && a_sr);
      if (a_q.size() > 0 && a_sr) void'(a_q.pop_front());
      if (a_rdy_m && a_lv) begin
        a_fb = frame_bits(a_ld, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) a_q.push_back(a_fb[i]);
      end
    end
  end

  always @(negedge clk) if (a_en) begin
    chk("a_valid", a_sv, a_q.size() > 0);
    chk("a_busy", a_busy, a_q.size() > 0);
    if (a_q.size() > 0) chk("a_sout", a_so, a_q[0]);
    else                chk("a_sout", a_so, 0);
    chk("a_last", a_sl, a_q.size() == 1);
    chk("a_ready", a_lr, (a_q.size() == 0) || (a_q.size() == 1 && a_sr));
    if (a_sv && a_sr) begin
      a_bits.push_back(a_so);
      if (a_sl) a_nlast++;
    end
  end

  task automatic a_send(input logic [7:0] d);
    int n;
    n = 0;
    a_lv = 1'b1; a_ld = d;
    do begin @(negedge clk); n++; end while (!a_lr && n < 60);
    if (n >= 60) chk("a_load_timeout", 0, 1);
    @(posedge clk); #1;
    a_lv = 1'b0; a_ld = 8'h00;
  endtask

  task automatic a_wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (a_sv && n < 60);
    if (n >= 60) chk("a_idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_a();
    int s, l;
    // reset state
    @(posedge clk); #1; a_rst = 1'b0; a_en = 1'b1;
    @(negedge clk);
    chk("a_rst_valid", a_sv, 0); chk("a_rst_sout", a_so, 0);
    chk("a_rst_last", a_sl, 0); chk("a_rst_ready", a_lr, 1);
    @(posedge clk); #1;
    // single word 0xA5
    s = a_bits.size(); l = a_nlast;
    a_send(8'hA5);
    @(negedge clk); chk("a5_first_bit", a_so, 1); chk("a5_first_valid", a_sv, 1);
    a_wait_idle();
    chk("a5_bits", pack(a_bits, s, 8), 32'hA5);
    chk("a5_count", a_bits.size() - s, 8);
    chk("a5_lastcnt", a_nlast - l, 1);
    @(negedge clk); chk("a5_after_valid", a_sv, 0); chk("a5_after_ready", a_lr, 1);
    @(posedge clk); #1;
    // backpressure on bit 2 of 0xF0
    s = a_bits.size();
    a_send(8'hF0);
    @(posedge clk); @(posedge clk); #1; a_sr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_sout", a_so, 1); chk("bp_valid", a_sv, 1); chk("bp_last", a_sl, 0);
      @(posedge clk);
    end
    #1; a_sr = 1'b1;
    a_wait_idle();
    chk("bp_bits", pack(a_bits, s, 8), 32'hF0);
    chk("bp_count", a_bits.size() - s, 8);
    // back-to-back 0x81, 0x7E
    s = a_bits.size();
    a_lv = 1'b1; a_ld = 8'h81;
    @(negedge clk); chk("b2b_ready0", a_lr, 1);
    @(posedge clk); #1; a_ld = 8'h7E;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("b2b_contig", a_sv, 1);
      if (i == 7) begin chk("b2b_ready_pulse", a_lr, 1); chk("b2b_last", a_sl, 1); end
      @(posedge clk); #1;
      if (i == 7) a_lv = 1'b0;
    end
    @(negedge clk); chk("b2b_end_valid", a_sv, 0);
    chk("b2b_bits", pack(a_bits, s, 16), 32'h817E);
    chk("b2b_count", a_bits.size() - s, 16);
    @(posedge clk); #1;
    // reset mid-frame of 0xFF, then 0x00
    a_send(8'hFF);
    repeat (3) @(posedge clk);
    #1; a_rst = 1'b1;
    @(posedge clk); #1; a_rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", a_sv, 0); chk("mid_rst_sout", a_so, 0); chk("mid_rst_ready", a_lr, 1);
    @(posedge clk); #1;
    s = a_bits.size(); l = a_nlast;
    a_send(8'h00);
    a_wait_idle();
    chk("zero_bits", pack(a_bits, s, 8), 32'h00);
    chk("zero_count", a_bits.size() - s, 8);
    chk("zero_lastcnt", a_nlast - l, 1);
    // ignored load pulse while busy
    s = a_bits.size();
    a_send(8'h3C);
    @(posedge clk); #1; a_lv = 1'b1; a_ld = 8'h55;
    @(posedge clk); #1; a_lv = 1'b0; a_ld = 8'h00;
    a_wait_idle();
    repeat (3) @(negedge clk);
    chk("ign_bits", pack(a_bits, s, 8), 32'h3C);
    chk("ign_count", a_bits.size() - s, 8);
    chk("ign_idle", a_sv, 0);
  endtask

  // ---------------- instance B: LSB first, even parity
  logic       b_rst = 1'b1, b_lv = 1'b0, b_sr = 1'b1;
  logic [7:0] b_ld = '0;
  logic       b_lr, b_so, b_sv, b_sl, b_busy;
  bit         b_en = 1'b0;
  bit         b_q[$];
  bit         b_bits[$];
  int         b_nlast = 0;
  bit         b_rdy_m;
  logic [32:0] b_fb;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1)) u_b (
    .clk(clk), .rst(b_rst), .load_valid(b_lv), .load_ready(b_lr), .load_data(b_ld),
    .sout(b_so), .sout_valid(b_sv), .sout_ready(b_sr), .sout_last(b_sl), .busy(b_busy));

  always @(posedge clk) begin
    if (b_rst) b_q.delete();
    else begin
      b_rdy_m = (b_q.size() == 0) || (b_q.size() == 1 && b_sr);
      if (b_q.size() > 0 && b_sr) void'(b_q.pop_front());
      if (b_rdy_m && b_lv) begin
        b_fb = frame_bits(b_ld, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) b_q.push_back(b_fb[i]);
      end
    end
  end

  always @(negedge clk) if (b_en) begin
    chk("b_valid", b_sv, b_q.size() > 0);
    chk("b_busy", b_busy, b_q.size() > 0);
    if (b_q.size() > 0) chk("b_sout", b_so, b_q[0]);
    else                chk("b_sout", b_so, 0);
    chk("b_last", b_sl, b_q.size() == 1);
    chk("b_ready", b_lr, (b_q.size() == 0) || (b_q.size() == 1 && b_sr));
    if (b_sv && b_sr) begin
      b_bits.push_back(b_so);
      if (b_sl) b_nlast++;
    end
  end

  task automatic b_frame(input logic [7:0] d, input logic [8:0] exp, input string nm);
    int s, l, n;
    s = b_bits.size(); l = b_nlast; n = 0;
    b_lv = 1'b1; b_ld = d;
    do begin @(negedge clk); n++; end while (!b_lr && n < 60);
    @(posedge clk); #1; b_lv = 1'b0; b_ld = 8'h00;
    n = 0;
    do begin @(negedge clk); n++; end while (b_sv && n < 60);
    if (n >= 60) chk({nm, "_timeout"}, 0, 1);
    chk({nm, "_bits"}, pack(b_bits, s, 9), {23'd0, exp});
    chk({nm, "_count"}, b_bits.size() - s, 9);
    chk({nm, "_lastcnt"}, b_nlast - l, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_b();
    @(posedge clk); #1; b_rst = 1'b0; b_en = 1'b1;
    @(negedge clk); chk("b_rst_ready", b_lr, 1); chk("b_rst_valid", b_sv, 0);
    @(posedge clk); #1;
    b_frame(8'h03, 9'b110000000, "par03");
    b_frame(8'h07, 9'b111000001, "par07");
  endtask

  initial begin
    // model pins
    chk("model_a5", frame_bits(8'hA5, 1'b1, 1'b0), 33'h0A5);
    chk("model_f0", frame_bits(8'hF0, 1'b1, 1'b0), 33'h00F);
    chk("model_03p", frame_bits(8'h03, 1'b0, 1'b1), 33'h003);
    chk("model_07p", frame_bits(8'h07, 1'b0, 1'b1), 33'h107);
    fork
      run_a();
      run_b();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
